// File: rtl/ifu_axi_master.sv
// rtl/ifu_axi_master.sv - instruction-fetch AXI-lite read initiator with redirect handling
module ifu_axi_master #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready,
    output logic [DATA_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_pc_o,
    output logic              inst_fault_o,
    output logic              inst_valid_o,
    input  logic              inst_ready_i,
    input  logic              redirect_valid_i,
    input  logic [ADDR_W-1:0] redirect_pc_i
);

    localparam logic [DATA_W-1:0] NOP = DATA_W'(32'h0000_0013);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_RESP = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t            r_state, w_state_next;
    logic [ADDR_W-1:0] r_pc, w_pc_next;
    logic              r_kill, w_kill_next;
    logic [ADDR_W-1:0] r_tgt, w_tgt_next;
    logic [DATA_W-1:0] r_inst, w_inst_next;
    logic [ADDR_W-1:0] r_inst_pc, w_inst_pc_next;
    logic              r_fault, w_fault_next;
    logic [ADDR_W-1:0] w_redir_pc;
    logic              w_resp_err;

    assign w_redir_pc = {redirect_pc_i[ADDR_W-1:2], 2'b00};
    assign w_resp_err = (rresp != 2'b00);

    // Handshake outputs decode the registered state; reset only masks them.
    assign arvalid      = (r_state == S_REQ)  && !rst;
    assign rready       = (r_state == S_RESP) && !rst;
    assign inst_valid_o = (r_state == S_OUT)  && !rst;
    assign araddr       = r_pc;
    assign inst_o       = r_inst;
    assign inst_pc_o    = r_inst_pc;
    assign inst_fault_o = r_fault;

    // Next-state logic: fetch sequencing, redirect capture and response discard.
    always_comb begin
        w_state_next   = r_state;
        w_pc_next      = r_pc;
        w_kill_next    = r_kill;
        w_tgt_next     = r_tgt;
        w_inst_next    = r_inst;
        w_inst_pc_next = r_inst_pc;
        w_fault_next   = r_fault;
        case (r_state)
            S_REQ: begin
                // The AR stays up at the old pc; the redirect is remembered
                // and the matching response will be thrown away.
                if (redirect_valid_i) begin
                    w_kill_next = 1'b1;
                    w_tgt_next  = w_redir_pc;
                end
                if (arready) begin
                    w_state_next = S_RESP;
                end
            end
            S_RESP: begin
                if (rvalid) begin
                    if (r_kill || redirect_valid_i) begin
                        w_pc_next    = redirect_valid_i ? w_redir_pc : r_tgt;
                        w_kill_next  = 1'b0;
                        w_state_next = S_REQ;
                    end else begin
                        w_inst_next    = w_resp_err ? NOP : rdata;
                        w_inst_pc_next = r_pc;
                        w_fault_next   = w_resp_err;
                        w_state_next   = S_OUT;
                    end
                end else if (redirect_valid_i) begin
                    w_kill_next = 1'b1;
                    w_tgt_next  = w_redir_pc;
                end
            end
            S_OUT: begin
                // A redirect wins over a same-cycle accept.
                if (redirect_valid_i) begin
                    w_pc_next    = w_redir_pc;
                    w_state_next = S_REQ;
                end else if (inst_ready_i) begin
                    w_pc_next    = r_pc + ADDR_W'(4);
                    w_state_next = S_REQ;
                end
            end
            default: begin
                w_state_next = S_REQ;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_REQ;
            r_pc      <= RESET_PC;
            r_kill    <= 1'b0;
            r_tgt     <= RESET_PC;
            r_inst    <= NOP;
            r_inst_pc <= '0;
            r_fault   <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_pc      <= w_pc_next;
            r_kill    <= w_kill_next;
            r_tgt     <= w_tgt_next;
            r_inst    <= w_inst_next;
            r_inst_pc <= w_inst_pc_next;
            r_fault   <= w_fault_next;
        end
    end

endmodule

// File: tb/tb_ifu_axi_master.sv
// tb/tb_ifu_axi_master.sv - directed and randomized self-checking bench for ifu_axi_master
module tb_ifu_axi_master;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_fault_o;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;

    ifu_axi_master dut (
        .clk              (clk),
        .rst              (rst),
        .araddr           (araddr),
        .arvalid          (arvalid),
        .arready          (arready),
        .rdata            (rdata),
        .rresp            (rresp),
        .rvalid           (rvalid),
        .rready           (rready),
        .inst_o           (inst_o),
        .inst_pc_o        (inst_pc_o),
        .inst_fault_o     (inst_fault_o),
        .inst_valid_o     (inst_valid_o),
        .inst_ready_i     (inst_ready_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Slave and reference-model state
    logic        s_pend = 1'b0;
    int          s_delay = 0;
    logic [31:0] s_addr = '0;
    logic [31:0] last_data = '0;
    logic [1:0]  last_resp = '0;
    logic [31:0] last_addr = '0;
    logic [31:0] m_next = RST_PC;
    logic        m_present = 1'b0;
    logic        f_taint = 1'b0;
    logic        prev_rst = 1'b0;
    logic        prev_wait = 1'b0;
    logic [31:0] prev_addr = '0;
    logic        dir_mode = 1'b1;
    logic [31:0] dir_data = '0;
    logic [1:0]  dir_resp = '0;
    int          deliveries = 0;

    logic        o_arvalid, o_rready, o_valid, o_fault;
    logic [31:0] o_araddr, o_inst, o_pc;

    task automatic cycle(input logic r, input logic a, input logic d, input logic v, input logic [31:0] t);
        rst              = r;
        arready          = a;
        inst_ready_i     = d;
        redirect_valid_i = v;
        redirect_pc_i    = t;
        rvalid           = !r && s_pend && (s_delay == 0);
        if (dir_mode) begin
            rdata = dir_data;
            rresp = dir_resp;
        end else begin
            rdata = $urandom;
            rresp = ($urandom_range(7) == 0) ? 2'b10 : 2'b00;
        end
        #1;
        o_arvalid = arvalid;
        o_rready  = rready;
        o_valid   = inst_valid_o;
        o_araddr  = araddr;
        o_inst    = inst_o;
        o_pc      = inst_pc_o;
        o_fault   = inst_fault_o;
        if (r) begin
            check("rst_arvalid", {31'd0, o_arvalid}, 32'd0);
            check("rst_rready", {31'd0, o_rready}, 32'd0);
            check("rst_valid", {31'd0, o_valid}, 32'd0);
            if (prev_rst) begin
                check("rst_inst", o_inst, NOP);
                check("rst_pc", o_pc, 32'd0);
                check("rst_fault", {31'd0, o_fault}, 32'd0);
            end
        end else begin
            if (prev_rst) begin
                check("rel_arvalid", {31'd0, o_arvalid}, 32'd1);
                check("rel_araddr", o_araddr, RST_PC);
            end
            if (prev_wait) begin
                check("ar_hold_v", {31'd0, o_arvalid}, 32'd1);
                check("ar_hold_addr", o_araddr, prev_addr);
            end
            check("rready", {31'd0, o_rready}, {31'd0, s_pend});
            check("present", {31'd0, o_valid}, {31'd0, m_present});
            if (o_arvalid) check("ar_excl", {30'd0, o_rready, o_valid}, 32'd0);
            if (m_present && d && !v) begin
                deliveries++;
                check("dlv_pc", o_pc, m_next);
                check("dlv_addr", o_pc, last_addr);
                check("dlv_inst", o_inst, (last_resp != 2'b00) ? NOP : last_data);
                check("dlv_fault", {31'd0, o_fault}, {31'd0, last_resp != 2'b00});
                m_next = o_pc + 32'd4;
            end
            if (v) begin
                if (o_arvalid || s_pend) f_taint = 1'b1;
                m_next = {t[31:2], 2'b00};
            end
        end
        prev_wait = !r && o_arvalid && !a;
        prev_addr = o_araddr;
        prev_rst  = r;
        @(posedge clk);
        if (r) begin
            s_pend    = 1'b0;
            m_present = 1'b0;
            f_taint   = 1'b0;
            m_next    = RST_PC;
        end else begin
            if (m_present && (d || v)) m_present = 1'b0;
            if (rvalid && o_rready) begin
                s_pend    = 1'b0;
                last_data = rdata;
                last_resp = rresp;
                last_addr = s_addr;
                m_present = !f_taint && !v;
                f_taint   = 1'b0;
            end else if (s_pend && s_delay > 0) begin
                s_delay--;
            end
            if (o_arvalid && a) begin
                s_pend  = 1'b1;
                s_addr  = o_araddr;
                s_delay = dir_mode ? 0 : int'($urandom_range(3));
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0;
        inst_ready_i = 1'b0; redirect_valid_i = 1'b0; redirect_pc_i = '0;
        @(negedge clk);

        dir_mode = 1'b1; dir_data = 32'h0000_0297; dir_resp = 2'b00;
        repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);

        cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        check("t1_arvalid", {31'd0, o_arvalid}, 32'd1);
        check("t1_araddr", o_araddr, 32'h8000_0000);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        check("t1_rready", {31'd0, o_rready}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
            check("t2_valid", {31'd0, o_valid}, 32'd1);
            check("t2_inst", o_inst, 32'h0000_0297);
            check("t2_pc", o_pc, 32'h8000_0000);
            check("t2_arvalid", {31'd0, o_arvalid}, 32'd0);
        end
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
            check("t3_arvalid", {31'd0, o_arvalid}, 32'd1);
            check("t3_araddr", o_araddr, 32'h8000_0004);
        end
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        check("t3_one_ar", {31'd0, o_arvalid}, 32'd0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
        check("t3_valid", {31'd0, o_valid}, 32'd1);

        dir_data = 32'hdead_beef;
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h8000_0102);
        check("t4_ar_kept", {31'd0, o_arvalid}, 32'd1);
        check("t4_ar_addr", o_araddr, 32'h8000_0008);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        dir_data = 32'h0050_0093;
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        check("t4_dropped", {31'd0, o_valid}, 32'd0);
        check("t4_araddr", o_araddr, 32'h8000_0100);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        dir_resp = 2'b10;
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h8000_0200);
        check("t5_valid", {31'd0, o_valid}, 32'd1);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        check("t5_araddr", o_araddr, 32'h8000_0200);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        dir_resp = 2'b00;
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
        check("t6_fault", {31'd0, o_fault}, 32'd1);
        check("t6_inst", o_inst, NOP);
        check("t6_pc", o_pc, 32'h8000_0200);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        check("t6_next", o_araddr, 32'h8000_0204);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        check("t6_top_addr", o_araddr, 32'hFFFF_FFFC);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
        check("t6_top_pc", o_pc, 32'hFFFF_FFFC);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        check("t6_wrap", o_araddr, 32'h0000_0000);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);

        dir_mode   = 1'b0;
        deliveries = 0;
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(199) == 0, 1'($urandom_range(1)), 1'($urandom_range(1)),
                  $urandom_range(9) == 0, $urandom);
        end
        check("liveness", {31'd0, deliveries > 100}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
